// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Package : i2s_pkg
// Brief   : Frame geometry, slot positions and control states shared by the
//           clock-master I2S codec port.
// Rev     : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int SLOT_BITS   = 32;
    localparam int FRAME_BITS  = 64;
    localparam int LEFT_FIRST  = 1;
    localparam int RIGHT_FIRST = 33;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;

    // True for bit periods that carry sample data (MSB one period after LRCLK edge)
    function automatic logic in_data_slot(input logic [5:0] b);
        return ((b >= 6'(LEFT_FIRST))  && (b < 6'(LEFT_FIRST  + SAMPLE_BITS))) ||
               ((b >= 6'(RIGHT_FIRST)) && (b < 6'(RIGHT_FIRST + SAMPLE_BITS)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
`default_nettype none
// ============================================================================
// Module : i2s_bclk_gen
// Brief  : Divides bus_clk into BCLK and flags the last cycle of each bit period.
// Rev    : 1.0 - initial release
// ============================================================================
module i2s_bclk_gen #(
    parameter int HALF_DIV = 16
) (
    input  logic bus_clk,
    input  logic srst,
    input  logic run,
    input  logic restart,
    output logic bclk,
    output logic fall_stb,
    output logic sample_stb
);

    localparam int              CW        = $clog2(2 * HALF_DIV);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(2 * HALF_DIV - 1);
    localparam logic [CW-1:0]   LOW_LAST  = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;

    always_comb begin
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (restart || !run || (cnt_q == LAST_CNT)) begin
            cnt_d  = '0;
            bclk_d = 1'b0;
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LOW_LAST) begin
                bclk_d = 1'b1;
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    // Both strobes mark the final high-phase cycle; the next edge starts a bit period
    assign fall_stb   = run && (cnt_q == LAST_CNT);
    assign sample_stb = run && (cnt_q == LAST_CNT);
    assign bclk       = bclk_q;

endmodule
`default_nettype wire

// File: rtl/i2s_master_codec.sv
`default_nettype none
// ============================================================================
// Module : i2s_master_codec
// Brief  : Clock-master 16-bit stereo I2S port: BCLK/LRCLK generation, ADC-line
//          serializer fed by a one-word holding register, DAC-line deserializer.
// Rev    : 1.0 - initial release
// ============================================================================
module i2s_master_codec
    import i2s_pkg::*;
#(
    parameter int HALF_DIV = 16
) (
    input  logic        bus_clk,
    input  logic        srst,
    input  logic        enable,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_adc,
    input  logic        i2s_dac,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        underrun,
    output logic        frame_start
);

    i2s_state_e  state_q, state_d;
    logic [5:0]  b_q;
    logic        lrclk_q, adc_q;
    logic [31:0] tx_sh_q, hold_data_q;
    logic        hold_full_q;
    logic [30:0] rx_sh_q;
    logic [31:0] rx_data_q;
    logic        rx_valid_q, underrun_q, frame_start_q;

    logic        w_fall, w_sample, w_frame_start, w_accept;
    logic [5:0]  w_b_next;

    i2s_bclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_bclk_gen (
        .bus_clk    (bus_clk),
        .srst       (srst),
        .run        (state_q == ST_RUN),
        .restart    (w_frame_start),
        .bclk       (i2s_bclk),
        .fall_stb   (w_fall),
        .sample_stb (w_sample)
    );

    assign w_b_next = b_q + 6'd1;
    assign w_accept = tx_valid && !hold_full_q;

    always_comb begin
        state_d       = state_q;
        w_frame_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d       = ST_RUN;
                    w_frame_start = 1'b1;
                end
            end
            ST_RUN: begin
                // enable is only honoured once the current frame has fully played out
                if (w_fall && (b_q == 6'(FRAME_BITS - 1))) begin
                    if (enable) begin
                        w_frame_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            b_q           <= '0;
            lrclk_q       <= 1'b1;
            adc_q         <= 1'b0;
            tx_sh_q       <= '0;
            hold_data_q   <= '0;
            hold_full_q   <= 1'b0;
            rx_sh_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;

            if (w_frame_start) begin
                b_q           <= '0;
                lrclk_q       <= 1'b0;
                adc_q         <= 1'b0;
                tx_sh_q       <= hold_full_q ? hold_data_q : '0;
                underrun_q    <= !hold_full_q;
                frame_start_q <= 1'b1;
            end else if (w_fall) begin
                if (b_q == 6'(FRAME_BITS - 1)) begin
                    b_q     <= '0;
                    lrclk_q <= 1'b1;
                    adc_q   <= 1'b0;
                end else begin
                    b_q     <= w_b_next;
                    lrclk_q <= (w_b_next >= 6'(SLOT_BITS));
                    if (in_data_slot(w_b_next)) begin
                        adc_q   <= tx_sh_q[31];
                        tx_sh_q <= {tx_sh_q[30:0], 1'b0};
                    end else begin
                        adc_q <= 1'b0;
                    end
                end
            end

            // A word written in the frame-start cycle survives into the next frame
            if (w_frame_start) begin
                hold_full_q <= w_accept;
            end else if (w_accept) begin
                hold_full_q <= 1'b1;
            end
            if (w_accept) begin
                hold_data_q <= tx_data;
            end

            if (w_sample && in_data_slot(b_q)) begin
                rx_sh_q <= {rx_sh_q[29:0], i2s_dac};
                if (b_q == 6'(RIGHT_FIRST + SAMPLE_BITS - 1)) begin
                    rx_data_q  <= {rx_sh_q, i2s_dac};
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

    assign i2s_lrclk   = lrclk_q;
    assign i2s_adc     = adc_q;
    assign tx_ready    = !hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign underrun    = underrun_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_master_codec.sv
`default_nettype none
// ============================================================================
// Module : tb_i2s_master_codec
// Brief  : Loopback bench; a frame-level reference model predicts pins, pulses
//          and received words, which a negedge monitor compares every cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_i2s_master_codec;

    localparam int HD        = 2;
    localparam int FRAME_CYC = 128 * HD;
    localparam int RX_POS    = 2 * HD * 49;

    logic        bus_clk;
    logic        srst;
    logic        enable;
    logic        i2s_bclk, i2s_lrclk, i2s_adc, i2s_dac;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, underrun, frame_start;

    assign i2s_dac = i2s_adc;

    i2s_master_codec #(
        .HALF_DIV (HD)
    ) dut (
        .bus_clk     (bus_clk),
        .srst        (srst),
        .enable      (enable),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_adc     (i2s_adc),
        .i2s_dac     (i2s_dac),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .underrun    (underrun),
        .frame_start (frame_start)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    int          checks = 0;
    int          errors = 0;
    logic        armed  = 1'b0;
    logic        m_run  = 1'b0;
    int          m_pos  = 0;
    logic [31:0] m_word = '0;
    logic        acc_p  = 1'b0;
    logic [31:0] acc_w_p = '0;
    logic        en_p   = 1'b0;
    logic        rst_p  = 1'b0;
    logic [31:0] hold_q[$];
    logic [31:0] rx_q[$];
    logic        ex_fs, ex_und, ex_bclk, ex_lr, ex_adc, ex_rv;
    int          bi, ph;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame timing from enable, contents from the accepted-word queue
    always @(negedge bus_clk) begin
        ex_fs  = 1'b0;
        ex_und = 1'b0;
        if (rst_p) begin
            armed = 1'b1;
            m_run = 1'b0;
            m_pos = 0;
            hold_q.delete();
            rx_q.delete();
            acc_p = 1'b0;
        end else if (m_run && m_pos < FRAME_CYC - 1) begin
            m_pos++;
        end else if (en_p) begin
            ex_fs = 1'b1;
            m_run = 1'b1;
            m_pos = 0;
            if (hold_q.size() == 0) begin
                ex_und = 1'b1;
                m_word = '0;
            end else begin
                m_word = hold_q.pop_front();
            end
            rx_q.push_back(m_word);
        end else begin
            m_run = 1'b0;
        end
        if (acc_p) hold_q.push_back(acc_w_p);

        if (armed) begin
            bi = m_pos / (2 * HD);
            ph = m_pos % (2 * HD);
            ex_bclk = m_run && (ph >= HD);
            ex_lr   = !m_run || (bi >= 32);
            ex_adc  = 1'b0;
            if (m_run && bi >= 1 && bi <= 16)  ex_adc = m_word[32 - bi];
            if (m_run && bi >= 33 && bi <= 48) ex_adc = m_word[48 - bi];
            ex_rv = m_run && (m_pos == RX_POS);

            chk("pins bclk/lrclk/adc", 32'({i2s_bclk, i2s_lrclk, i2s_adc}), 32'({ex_bclk, ex_lr, ex_adc}));
            chk("tx_ready", 32'(tx_ready), 32'(hold_q.size() == 0));
            chk("frame_start", 32'(frame_start), 32'(ex_fs));
            chk("underrun", 32'(underrun), 32'(ex_und));
            chk("rx_valid", 32'(rx_valid), 32'(ex_rv));
            if (rx_valid && rx_q.size() > 0) chk("rx_data", rx_data, rx_q.pop_front());
            if (rst_p) chk("reset rx_data", rx_data, 32'h0);
        end

        acc_p   = tx_valid && tx_ready;
        acc_w_p = tx_data;
        en_p    = enable;
        rst_p   = srst;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge bus_clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge bus_clk);
        while (!tx_ready) begin
            n++;
            if (n > 4 * FRAME_CYC) begin
                $display("FAIL send: tx_ready stuck at %b, required 1", tx_ready);
                $fatal(1);
            end
            @(negedge bus_clk);
        end
        @(posedge bus_clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = $urandom();
    endtask

    task automatic wait_fs();
        int n = 0;
        @(negedge bus_clk);
        while (!frame_start) begin
            n++;
            if (n > 4 * FRAME_CYC) begin
                $display("FAIL wait_fs: frame_start stuck at %b, required 1", frame_start);
                $fatal(1);
            end
            @(negedge bus_clk);
        end
        @(posedge bus_clk);
        #1;
    endtask

    initial begin
        srst     = 1'b1;
        enable   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        cycles(3);
        srst = 1'b0;
        cycles(10);

        // Single loopback frame, enable withdrawn right after it starts
        send(32'hA5A5_3C3C);
        enable = 1'b1;
        wait_fs();
        enable = 1'b0;
        cycles(FRAME_CYC + 20);

        // Continuous frames with random words and random underruns
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || $urandom_range(0, 3) != 0) begin
                cycles(int'($urandom_range(0, 200)));
                send((i == 0) ? 32'h8001_7FFE : $urandom());
            end
            wait_fs();
        end

        // Word written exactly in a frame-start cycle with the register empty
        wait_fs();
        cycles(FRAME_CYC - 2);
        send($urandom());
        wait_fs();
        wait_fs();

        // Enable dropped at bit period 10
        send($urandom());
        wait_fs();
        cycles(2 * HD * 10);
        enable = 1'b0;
        cycles(FRAME_CYC + 50);

        // Reset at bit period 40 with the holding register full
        send($urandom());
        enable = 1'b1;
        wait_fs();
        send($urandom());
        cycles(2 * HD * 40 - 2);
        srst   = 1'b1;
        enable = 1'b0;
        cycles(1);
        srst = 1'b0;
        cycles(FRAME_CYC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
